// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the mode enumeration, fixed code words and a popcount helper.
// Code words are written with bit 9 leftmost; bit 0 is the first bit on the wire.
package tmds_pkg;

   typedef enum logic [1:0] {
      MODE_CTRL  = 2'd0,
      MODE_VIDEO = 2'd1,
      MODE_TERC4 = 2'd2,
      MODE_GUARD = 2'd3
   } tmds_mode_e;

   localparam logic [9:0] CTRL_CODE [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };

   localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
   localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

   localparam logic [9:0] TERC4_CODE [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   function automatic logic [3:0] n1(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: stage 1 forms q_m, stage 2 applies running disparity or a fixed code.
// Define TMDS_TERC4_EN to encode mode 2 as TERC4; otherwise mode 2 is a control symbol.
module tmds_lane
   import tmds_pkg::*;
#(
   parameter int LANE_IDX = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [1:0] mode,
   input  logic [7:0] vd,
   input  logic [1:0] cd,
   input  logic [3:0] aux,
   output logic [9:0] tmds
);

   logic [8:0]  q_m_d, q_m_q;
   tmds_mode_e  mode_d, mode_q;
   logic [1:0]  cd_d, cd_q;
   logic [3:0]  aux_d, aux_q;
   logic        s1_valid_d, s1_valid_q;
   logic [9:0]  tmds_d, tmds_q;
   logic [4:0]  cnt_d, cnt_q;

   logic [3:0]  vd_ones;
   logic        use_xnor;
   logic [8:0]  q_m_calc;
   logic [3:0]  qm_ones;
   logic [4:0]  diff;

   always_comb begin
      vd_ones  = n1(vd);
      use_xnor = (vd_ones > 4'd4) || ((vd_ones == 4'd4) && !vd[0]);
      q_m_calc = '0;
      q_m_calc[0] = vd[0];
      for (int i = 1; i < 8; i++)
         q_m_calc[i] = use_xnor ? ~(q_m_calc[i-1] ^ vd[i]) : (q_m_calc[i-1] ^ vd[i]);
      q_m_calc[8] = ~use_xnor;

      q_m_d      = q_m_q;
      mode_d     = mode_q;
      cd_d       = cd_q;
      aux_d      = aux_q;
      s1_valid_d = in_valid;
      if (in_valid) begin
         q_m_d  = q_m_calc;
         mode_d = tmds_mode_e'(mode);
         cd_d   = cd;
         aux_d  = aux;
      end
   end

   // cnt and diff are two's complement; all arithmetic wraps modulo 32.
   always_comb begin
      qm_ones = n1(q_m_q[7:0]);
      diff    = {qm_ones, 1'b0} - 5'd8;
      tmds_d  = tmds_q;
      cnt_d   = cnt_q;
      if (s1_valid_q) begin
         cnt_d = '0;
         case (mode_q)
            MODE_VIDEO: begin
               if ((cnt_q == 5'd0) || (qm_ones == 4'd4)) begin
                  tmds_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
                  cnt_d  = q_m_q[8] ? (cnt_q + diff) : (cnt_q - diff);
               end else if ((!cnt_q[4] && !diff[4]) || (cnt_q[4] && diff[4])) begin
                  tmds_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
                  cnt_d  = cnt_q + {3'b000, q_m_q[8], 1'b0} - diff;
               end else begin
                  tmds_d = {1'b0, q_m_q[8], q_m_q[7:0]};
                  cnt_d  = cnt_q + diff - (q_m_q[8] ? 5'd0 : 5'd2);
               end
            end
            MODE_GUARD: tmds_d = ((LANE_IDX % 2) == 0) ? GUARD_EVEN : GUARD_ODD;
`ifdef TMDS_TERC4_EN
            MODE_TERC4: tmds_d = TERC4_CODE[aux_q];
`else
            MODE_TERC4: tmds_d = CTRL_CODE[cd_q];
`endif
            default:    tmds_d = CTRL_CODE[cd_q];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_m_q      <= '0;
         mode_q     <= MODE_CTRL;
         cd_q       <= '0;
         aux_q      <= '0;
         s1_valid_q <= 1'b0;
         tmds_q     <= '0;
         cnt_q      <= '0;
      end else begin
         q_m_q      <= q_m_d;
         mode_q     <= mode_d;
         cd_q       <= cd_d;
         aux_q      <= aux_d;
         s1_valid_q <= s1_valid_d;
         tmds_q     <= tmds_d;
         cnt_q      <= cnt_d;
      end
   end

   assign tmds = tmds_q;

endmodule

// File: rtl/tmds_encoder_multi.sv
// Multi-lane TMDS encoder: CHANNELS independent lanes behind a shared 2-stage valid pipeline.
// Define TMDS_TERC4_EN to enable TERC4 data-island encoding in mode 2.
module tmds_encoder_multi
   import tmds_pkg::*;
#(
   parameter int CHANNELS = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [1:0]             mode,
   input  logic [CHANNELS*8-1:0]  vd,
   input  logic [CHANNELS*2-1:0]  cd,
   input  logic [CHANNELS*4-1:0]  aux,
   output logic                   out_valid,
   output logic [CHANNELS*10-1:0] tmds
);

   // in_valid is a pure qualifier with no backpressure: every input accepted with
   // in_valid=1 reappears two edges later with out_valid=1, one symbol per clk.
   logic v1_d, v1_q;
   logic out_valid_d, out_valid_q;

   always_comb begin
      v1_d        = in_valid;
      out_valid_d = v1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         v1_q        <= v1_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      tmds_lane #(.LANE_IDX(g)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid),
         .mode     (mode),
         .vd       (vd[8*g +: 8]),
         .cd       (cd[2*g +: 2]),
         .aux      (aux[4*g +: 4]),
         .tmds     (tmds[10*g +: 10])
      );
   end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Bench for tmds_encoder_multi: directed scenarios plus a random stream against a DVI model.
// Mode 2 expectations follow TMDS_TERC4_EN.
module tb_tmds_encoder_multi;

   localparam int CH = 4;
   localparam int W  = 1 + CH*10;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic [1:0]      mode;
   logic [CH*8-1:0] vd;
   logic [CH*2-1:0] cd;
   logic [CH*4-1:0] aux;
   logic            out_valid;
   logic [CH*10-1:0] tmds;

   tmds_encoder_multi #(.CHANNELS(CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .mode      (mode),
      .vd        (vd),
      .cd        (cd),
      .aux       (aux),
      .out_valid (out_valid),
      .tmds      (tmds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [9:0] REF_CTRL [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };
`ifdef TMDS_TERC4_EN
   localparam logic [9:0] REF_TERC4 [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };
`endif

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_now;
   bit           exp_now_ok;
   int           cnt_m [CH];
   logic [9:0]   sym_m [CH];
   int           n_vec;
   int           n_err;

   function automatic int ones8(input logic [7:0] v);
      int c;
      c = 0;
      for (int i = 0; i < 8; i++) c += int'(v[i]);
      return c;
   endfunction

   // DVI 1.0 video encoding with integer disparity; q_m taken as prefix parity.
   function automatic logic [9:0] video_sym(input logic [7:0] d, input int cnt_in, output int cnt_out);
      int         k, ones, zeros;
      bit         inv;
      logic       p;
      logic [8:0] qm;
      logic [9:0] s;
      k   = ones8(d);
      inv = (k > 4) || (k == 4 && d[0] == 1'b0);
      p   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p     = p ^ d[i];
         qm[i] = p ^ (inv && (i % 2 == 1));
      end
      qm[8] = !inv;
      ones  = ones8(qm[7:0]);
      zeros = 8 - ones;
      if (cnt_in == 0 || ones == zeros) begin
         s       = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cnt_out = cnt_in + (qm[8] ? (ones - zeros) : (zeros - ones));
      end else if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
         s       = {1'b1, qm[8], ~qm[7:0]};
         cnt_out = cnt_in + 2*int'(qm[8]) + (zeros - ones);
      end else begin
         s       = {1'b0, qm[8], qm[7:0]};
         cnt_out = cnt_in + (ones - zeros) - (qm[8] ? 0 : 2);
      end
      return s;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      exp_now_ok = 1'b0;
      for (int l = 0; l < CH; l++) begin
         cnt_m[l] = 0;
         sym_m[l] = '0;
      end
   endtask

   // Drive one cycle, update the model, then expose the expectation for the visible output.
   task automatic drive(input bit v, input logic [1:0] m, input logic [CH*8-1:0] d,
                        input logic [CH*2-1:0] c, input logic [CH*4-1:0] a);
      logic [CH*10-1:0] flat;
      int               nc;
      in_valid = v;
      mode     = m;
      vd       = d;
      cd       = c;
      aux      = a;
      for (int l = 0; l < CH; l++) begin
         if (v) begin
            if (m == 2'd1) begin
               sym_m[l] = video_sym(d[8*l +: 8], cnt_m[l], nc);
               cnt_m[l] = nc;
            end else begin
               cnt_m[l] = 0;
               if (m == 2'd3) sym_m[l] = (l % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
`ifdef TMDS_TERC4_EN
               else if (m == 2'd2) sym_m[l] = REF_TERC4[a[4*l +: 4]];
`endif
               else sym_m[l] = REF_CTRL[c[2*l +: 2]];
            end
         end
         flat[10*l +: 10] = sym_m[l];
      end
      exp_q.push_back({v, flat});
      @(posedge clk);
      #1;
      exp_now_ok = (exp_q.size() > 1);
      if (exp_now_ok) exp_now = exp_q.pop_front();
   endtask

   function automatic logic [CH*8-1:0] rand_vd();
      logic [CH*8-1:0] r;
      for (int l = 0; l < CH; l++) r[8*l +: 8] = 8'($urandom_range(0, 255));
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; mode = 2'd0; vd = '0; cd = '0; aux = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++;
      if (tmds !== '0) begin n_err++; $display("FAIL reset_tmds: got %h want 0", tmds); end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) drive(1'b1, 2'd1, rand_vd(), '0, '0);
      #3 rst_n = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
      n_vec++;
      if (tmds !== '0) begin n_err++; $display("FAIL midreset_tmds: got %h want 0", tmds); end
      in_valid = 1'b1; mode = 2'd0; cd = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      drive(1'b1, 2'd0, '0, '0, '0);
      n_vec++;
      if (out_valid !== 1'b0 || tmds !== '0) begin
         n_err++; $display("FAIL post_reset_edge1: got valid=%b tmds=%h want valid=0 tmds=0", out_valid, tmds);
      end
      drive(1'b0, 2'd0, '0, '0, '0);
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_valid: got %b want 1", out_valid); end
      for (int l = 0; l < CH; l++) begin
         n_vec++;
         if (tmds[10*l +: 10] !== 10'b1101010100) begin
            n_err++; $display("FAIL post_reset_lane%0d: got %b want 1101010100", l, tmds[10*l +: 10]);
         end
      end
   endtask

   task automatic test_video_zero();
      logic [9:0] zv [4];
      zv = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
      for (int i = 0; i < 6; i++) begin
         if (i == 0)      drive(1'b1, 2'd0, '0, '0, '0);
         else if (i <= 4) drive(1'b1, 2'd1, '0, '0, '0);
         else             drive(1'b0, 2'd1, '0, '0, '0);
         if (i >= 2) begin
            for (int l = 0; l < CH; l++) begin
               n_vec++;
               if (tmds[10*l +: 10] !== zv[i-2]) begin
                  n_err++; $display("FAIL video_zero[%0d] lane%0d: got %h want %h", i-2, l, tmds[10*l +: 10], zv[i-2]);
               end
            end
         end
      end
   endtask

   task automatic test_bubble();
      bit         ov [6];
      logic [9:0] tv [6];
      ov = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tv = '{10'h000, 10'h000, 10'h100, 10'h100, 10'h3FF, 10'h3FF};
      for (int i = 0; i < 6; i++) begin
         case (i)
            0:       drive(1'b1, 2'd0, '0, '0, '0);
            1, 3:    drive(1'b1, 2'd1, '0, '0, '0);
            default: drive(1'b0, 2'd1, '0, '0, '0);
         endcase
         if (i >= 1) begin
            n_vec++;
            if (out_valid !== ov[i]) begin
               n_err++; $display("FAIL bubble_valid[%0d]: got %b want %b", i, out_valid, ov[i]);
            end
         end
         if (i >= 2) begin
            n_vec++;
            if (tmds[9:0] !== tv[i]) begin
               n_err++; $display("FAIL bubble_tmds[%0d]: got %h want %h", i, tmds[9:0], tv[i]);
            end
         end
      end
   endtask

   task automatic test_guard();
      logic [9:0] g;
      drive(1'b1, 2'd3, rand_vd(), '0, '0);
      drive(1'b0, 2'd0, '0, '0, '0);
      for (int l = 0; l < CH; l++) begin
         g = (l % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
         n_vec++;
         if (tmds[10*l +: 10] !== g) begin
            n_err++; $display("FAIL guard_lane%0d: got %b want %b", l, tmds[10*l +: 10], g);
         end
      end
   endtask

   task automatic test_mode2();
      logic [9:0] want;
`ifdef TMDS_TERC4_EN
      want = 10'b0100111001;
`else
      want = 10'b1010101011;
`endif
      drive(1'b1, 2'd2, rand_vd(), {CH{2'b11}}, {CH{4'h9}});
      drive(1'b0, 2'd0, '0, '0, '0);
      for (int l = 0; l < CH; l++) begin
         n_vec++;
         if (tmds[10*l +: 10] !== want) begin
            n_err++; $display("FAIL mode2_lane%0d: got %b want %b", l, tmds[10*l +: 10], want);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit              v;
      logic [1:0]      m;
      logic [CH*2-1:0] c;
      logic [CH*4-1:0] a;
      int              r;
      for (int n = 0; n < 14000; n++) begin
         v = ($urandom_range(0, 9) != 0);
         r = $urandom_range(0, 19);
         m = (r < 15) ? 2'd1 : (r < 17) ? 2'd0 : (r < 18) ? 2'd2 : 2'd3;
         for (int l = 0; l < CH; l++) begin
            c[2*l +: 2] = 2'($urandom_range(0, 3));
            a[4*l +: 4] = 4'($urandom_range(0, 15));
         end
         drive(v, m, rand_vd(), c, a);
         if (exp_now_ok) begin
            n_vec++;
            if ({out_valid, tmds} !== exp_now) begin
               n_err++;
               $display("FAIL stream[%0d]: got valid=%b tmds=%h want valid=%b tmds=%h",
                        n, out_valid, tmds, exp_now[W-1], exp_now[W-2:0]);
            end
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_video_zero();
      test_bubble();
      test_guard();
      test_mode2();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
